// File: rtl/snn_frame_ctrl_pkg.sv
// ============================================================================
// Module   : snn_pkg
// Brief    : Shared state encoding and frame geometry for snn_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package snn_pkg;

   localparam int NUM_PIXELS   = 784;
   localparam int PIXEL_ADDR_W = 10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      GAP   = 3'd2,
      START = 3'd3,
      RUN   = 3'd4,
      SEND  = 3'd5,
      TXW   = 3'd6
   } state_e;

endpackage

`default_nettype wire

// File: rtl/snn_frame_ctrl_if.sv
// ============================================================================
// Module   : snn_frame_ctrl_if
// Brief    : UART, input-RAM and core handshake bundle of the frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface snn_frame_ctrl_if
   import snn_pkg::*;
#(
   parameter int ADDR_W = PIXEL_ADDR_W
);

   logic              rx_rdy;
   logic [7:0]        rx_data;
   logic              ram_we;
   logic              ram_wdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [ADDR_W-1:0] core_addr;
   logic              core_start;
   logic              core_done;
   logic [3:0]        core_digit;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_rdy;
   logic              busy;
   logic              overrun;

   // Controller side
   modport master (
      input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_rdy,
      output ram_we, ram_wdata, ram_addr, core_start, tx_start, tx_data,
             busy, overrun
   );

   // Environment side (UART, RAM, core)
   modport slave (
      output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_rdy,
      input  ram_we, ram_wdata, ram_addr, core_start, tx_start, tx_data,
             busy, overrun
   );

endinterface

`default_nettype wire

// File: rtl/snn_frame_ctrl.sv
// ============================================================================
// Module   : snn_frame_ctrl
// Brief    : Unpacks a received image frame into the pixel RAM, runs the SNN
//            core and returns the classified digit. Optional FRAME_TIMEOUT_EN
//            aborts a frame stalled mid-stream for TIMEOUT_CYC cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_frame_ctrl
   import snn_pkg::*;
#(
   parameter int         NUM_BYTES     = NUM_PIXELS / 8,
   parameter int         ADDR_W        = PIXEL_ADDR_W,
   parameter logic [3:0] RESULT_PREFIX = 4'h3
`ifdef FRAME_TIMEOUT_EN
   ,
   parameter int         TIMEOUT_CYC   = 500000
`endif
)(
   input  logic             clk,
   input  logic             rst_n,
   snn_frame_ctrl_if.master ctrl_if
);

   localparam int                BYTE_W    = ADDR_W - 3;
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

   state_e            state_q,    state_d;
   logic [7:0]        shift_q,    shift_d;
   logic [2:0]        bit_cnt_q,  bit_cnt_d;
   logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]        hold_q,     hold_d;
   logic              hold_vld_q, hold_vld_d;
   logic              overrun_q,  overrun_d;
   logic [7:0]        tx_data_q,  tx_data_d;
   logic              guard_q,    guard_d;

`ifdef FRAME_TIMEOUT_EN
   localparam int               GAP_W    = $clog2(TIMEOUT_CYC);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         overrun_q  <= 1'b0;
         tx_data_q  <= '0;
         guard_q    <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
         gap_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         overrun_q  <= overrun_d;
         tx_data_q  <= tx_data_d;
         guard_q    <= guard_d;
`ifdef FRAME_TIMEOUT_EN
         gap_cnt_q  <= gap_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      overrun_d  = overrun_q;
      tx_data_d  = tx_data_q;
      guard_d    = 1'b0;
`ifdef FRAME_TIMEOUT_EN
      gap_cnt_d  = '0;
`endif

      case (state_q)
         IDLE: begin
            if (ctrl_if.rx_rdy) begin
               shift_d    = ctrl_if.rx_data;
               bit_cnt_d  = '0;
               byte_cnt_d = '0;
               hold_vld_d = 1'b0;
               overrun_d  = 1'b0;
               state_d    = LOAD;
            end
         end

         LOAD: begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (ctrl_if.rx_rdy) begin
               if (hold_vld_q) begin
                  overrun_d = 1'b1;
               end else begin
                  hold_d     = ctrl_if.rx_data;
                  hold_vld_d = 1'b1;
               end
            end
            if (bit_cnt_q == 3'd7) begin
               if (byte_cnt_q == LAST_BYTE) begin
                  // Anything queued beyond the last byte belongs to no frame.
                  if (ctrl_if.rx_rdy || hold_vld_q) begin
                     overrun_d = 1'b1;
                  end
                  hold_vld_d = 1'b0;
                  state_d    = START;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  if (hold_vld_q) begin
                     shift_d    = hold_q;
                     hold_vld_d = 1'b0;
                  end else begin
                     state_d = GAP;
                  end
               end
            end
         end

         GAP: begin
            if (hold_vld_q) begin
               shift_d    = hold_q;
               hold_vld_d = ctrl_if.rx_rdy;
               if (ctrl_if.rx_rdy) begin
                  hold_d = ctrl_if.rx_data;
               end
               state_d = LOAD;
            end else if (ctrl_if.rx_rdy) begin
               shift_d = ctrl_if.rx_data;
               state_d = LOAD;
            end
`ifdef FRAME_TIMEOUT_EN
            else if (gap_cnt_q == GAP_LAST) begin
               byte_cnt_d = '0;
               state_d    = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
`endif
         end

         START: begin
            state_d = RUN;
         end

         RUN: begin
            if (ctrl_if.core_done) begin
               tx_data_d = {RESULT_PREFIX, ctrl_if.core_digit};
               state_d   = SEND;
            end
         end

         SEND: begin
            if (ctrl_if.tx_rdy) begin
               guard_d = 1'b1;
               state_d = TXW;
            end
         end

         TXW: begin
            // tx_rdy may still read high the cycle after tx_start; skip it.
            if (!guard_q && ctrl_if.tx_rdy) begin
               byte_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (ctrl_if.rx_rdy && ((state_q == START) || (state_q == RUN) ||
                             (state_q == SEND)  || (state_q == TXW))) begin
         overrun_d = 1'b1;
      end
   end

   assign ctrl_if.ram_we     = (state_q == LOAD);
   assign ctrl_if.ram_wdata  = shift_q[0];
   assign ctrl_if.ram_addr   = ctrl_if.ram_we ? {byte_cnt_q, bit_cnt_q}
                                              : ctrl_if.core_addr;
   assign ctrl_if.core_start = (state_q == START);
   assign ctrl_if.tx_start   = (state_q == SEND) && ctrl_if.tx_rdy;
   assign ctrl_if.tx_data    = tx_data_q;
   assign ctrl_if.busy       = (state_q != IDLE);
   assign ctrl_if.overrun    = overrun_q;

endmodule

`default_nettype wire
